// File: rtl/bp_lce_busy_governor.sv
// LCE busy governor: per-port stall timeouts, programmable busy hold,
// outstanding-request credits and a saturating timeout event counter.
module bp_lce_busy_governor #(
  parameter int unsigned num_ports_p     = 3,
  parameter int unsigned timeout_limit_p = 4,
  parameter int unsigned hold_cycles_p   = 2,
  parameter int unsigned credits_p       = 2,
  parameter int unsigned event_width_p   = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     timeout_en_i,
  input  logic [num_ports_p-1:0]   pkt_v_i,
  input  logic [num_ports_p-1:0]   pkt_yumi_i,
  input  logic                     req_ready_i,
  input  logic                     cmd_ready_i,
  input  logic                     credit_alloc_i,
  input  logic                     credit_return_i,
  output logic                     credits_full_o,
  output logic                     credits_empty_o,
  output logic                     cache_req_busy_o,
  output logic                     timeout_o,
  output logic [num_ports_p-1:0]   timeout_ports_o,
  output logic [event_width_p-1:0] timeout_events_o
);

  localparam int unsigned cnt_width_lp    = $clog2(timeout_limit_p + 1);
  localparam int unsigned hold_width_lp   = (hold_cycles_p > 1) ? $clog2(hold_cycles_p) : 1;
  localparam int unsigned credit_width_lp = $clog2(credits_p + 1);
  localparam int unsigned hold_load_int_lp = (hold_cycles_p > 0) ? (hold_cycles_p - 1) : 0;

  localparam logic [cnt_width_lp-1:0]    cnt_max_lp    = cnt_width_lp'(timeout_limit_p);
  localparam logic [hold_width_lp-1:0]   hold_load_lp  = hold_width_lp'(hold_load_int_lp);
  localparam logic [credit_width_lp-1:0] credit_max_lp = credit_width_lp'(credits_p);

  typedef enum logic {
    e_idle,
    e_hold
  } state_e;

  logic [cnt_width_lp-1:0]    cnt_r [num_ports_p];
  logic [hold_width_lp-1:0]   hold_cnt_r;
  logic [credit_width_lp-1:0] credit_r;
  state_e                     state_r;
  logic                       sat_en_r;
  logic                       any_sat;
  logic                       sat_en;
  logic                       events_max;

  // Per-port stall counters: count consecutive blocked cycles, saturating.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(num_ports_p); i++) begin
      if (reset_i) begin
        cnt_r[i] <= '0;
      end else if (pkt_v_i[i] & ~pkt_yumi_i[i]) begin
        if (cnt_r[i] != cnt_max_lp) cnt_r[i] <= cnt_r[i] + cnt_width_lp'(1);
      end else begin
        cnt_r[i] <= '0;
      end
    end
  end

  // Saturated-port mask decoded from the registered counters.
  always_comb begin
    timeout_ports_o = '0;
    for (int i = 0; i < int'(num_ports_p); i++) begin
      timeout_ports_o[i] = (cnt_r[i] == cnt_max_lp);
    end
  end

  assign any_sat    = |timeout_ports_o;
  assign sat_en     = timeout_en_i & any_sat;
  assign events_max = &timeout_events_o;

  // Busy-hold FSM and timeout event counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r          <= e_idle;
      hold_cnt_r       <= '0;
      timeout_events_o <= '0;
      sat_en_r         <= 1'b0;
    end else begin
      sat_en_r <= sat_en;
      if (hold_cycles_p == 0) begin
        // No hold: events mark rising edges of enabled saturation.
        state_r    <= e_idle;
        hold_cnt_r <= '0;
        if (sat_en & ~sat_en_r & ~events_max)
          timeout_events_o <= timeout_events_o + event_width_p'(1);
      end else begin
        case (state_r)
          e_idle: begin
            if (sat_en) begin
              state_r    <= e_hold;
              hold_cnt_r <= hold_load_lp;
              if (~events_max) timeout_events_o <= timeout_events_o + event_width_p'(1);
            end
          end
          e_hold: begin
            if (~timeout_en_i) begin
              state_r <= e_idle;
            end else if (hold_cnt_r != '0) begin
              hold_cnt_r <= hold_cnt_r - hold_width_lp'(1);
            end else if (any_sat) begin
              // Still saturated: extend the hold without a new event.
              hold_cnt_r <= hold_load_lp;
            end else begin
              state_r <= e_idle;
            end
          end
          default: state_r <= e_idle;
        endcase
      end
    end
  end

  assign timeout_o = timeout_en_i & (any_sat | (state_r == e_hold));

  // Outstanding-request credit counter; illegal updates hold the count.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      credit_r <= '0;
    end else begin
      case ({credit_alloc_i, credit_return_i})
        2'b10: begin
          assert (credit_r != credit_max_lp) else $error("credit alloc while full");
          if (credit_r != credit_max_lp) credit_r <= credit_r + credit_width_lp'(1);
        end
        2'b01: begin
          assert (credit_r != '0) else $error("credit return while empty");
          if (credit_r != '0) credit_r <= credit_r - credit_width_lp'(1);
        end
        default: credit_r <= credit_r;
      endcase
    end
  end

  assign credits_full_o   = (credit_r == credit_max_lp);
  assign credits_empty_o  = (credit_r == '0);
  assign cache_req_busy_o = credits_full_o | timeout_o | ~cmd_ready_i | ~req_ready_i;

endmodule
